// File: rtl/axis_lfsr_checker_if.sv
// AXI-Stream beat channel between an upstream master and the LFSR checker sink.
interface axis_lfsr_checker_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_lfsr_checker.sv
// AXI-Stream sink that accepts beats under LFSR-driven backpressure and checks them
// against an LFSR data sequence, counting beats, mismatches and upstream hold violations.
module axis_lfsr_checker #(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] SEED        = 32'h0000_0001,
   parameter logic [15:0] READY_SEED  = 16'hBEEF,
   parameter int          STALL_NUM   = 5,
   parameter int          COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [COUNT_WIDTH-1:0] target_count_i,
   axis_lfsr_checker_if.slave     s_axis,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [COUNT_WIDTH-1:0] rx_count_o,
   output logic [COUNT_WIDTH-1:0] error_count_o,
   output logic [DATA_WIDTH-1:0]  first_err_data_o,
   output logic [DATA_WIDTH-1:0]  first_err_exp_o,
   output logic                   protocol_err_o
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [4:0] STALL_W = 5'(STALL_NUM);

   logic [1:0]             state_q,      state_d;
   logic [31:0]            data_lfsr_q,  data_lfsr_d;
   logic [15:0]            rdy_lfsr_q,   rdy_lfsr_d;
   logic                   tready_q,     tready_d;
   logic [COUNT_WIDTH-1:0] target_q,     target_d;
   logic [COUNT_WIDTH-1:0] rx_count_q,   rx_count_d;
   logic [COUNT_WIDTH-1:0] err_count_q,  err_count_d;
   logic [DATA_WIDTH-1:0]  first_data_q, first_data_d;
   logic [DATA_WIDTH-1:0]  first_exp_q,  first_exp_d;
   logic [DATA_WIDTH-1:0]  held_data_q,  held_data_d;
   logic                   held_q,       held_d;
   logic                   proto_q,      proto_d;

   logic                   start_ok;
   logic                   handshake;
   logic                   mismatch;
   logic [DATA_WIDTH-1:0]  exp_data;
   logic [COUNT_WIDTH-1:0] rx_inc;
   logic [31:0]            data_step;
   logic [15:0]            rdy_step;

   assign start_ok  = start_i && (state_q != ST_RUN);
   assign handshake = (state_q == ST_RUN) && s_axis.tvalid && tready_q;
   assign exp_data  = data_lfsr_q[DATA_WIDTH-1:0];
   assign mismatch  = (s_axis.tdata != exp_data);
   assign rx_inc    = rx_count_q + 1'b1;
   assign data_step = {data_lfsr_q[30:0],
                       data_lfsr_q[31] ^ data_lfsr_q[21] ^ data_lfsr_q[1] ^ data_lfsr_q[0]};
   assign rdy_step  = {rdy_lfsr_q[14:0],
                       rdy_lfsr_q[15] ^ rdy_lfsr_q[13] ^ rdy_lfsr_q[12] ^ rdy_lfsr_q[10]};

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
      state_d      = state_q;
      data_lfsr_d  = data_lfsr_q;
      rdy_lfsr_d   = rdy_lfsr_q;
      target_d     = target_q;
      rx_count_d   = rx_count_q;
      err_count_d  = err_count_q;
      first_data_d = first_data_q;
      first_exp_d  = first_exp_q;
      held_data_d  = held_data_q;
      held_d       = held_q;
      proto_d      = proto_q;

      if (start_ok) begin
         target_d     = target_count_i;
         rx_count_d   = '0;
         err_count_d  = '0;
         first_data_d = '0;
         first_exp_d  = '0;
         held_d       = 1'b0;
         proto_d      = 1'b0;
         data_lfsr_d  = SEED;
         rdy_lfsr_d   = READY_SEED;
         state_d      = (target_count_i == '0) ? ST_DONE : ST_RUN;
      end else if (state_q == ST_RUN) begin
         rdy_lfsr_d = rdy_step;
         // A stalled beat must reappear unchanged until it is accepted.
         if (held_q && (!s_axis.tvalid || (s_axis.tdata != held_data_q))) begin
            proto_d = 1'b1;
         end
         held_d = s_axis.tvalid && !tready_q;
         if (s_axis.tvalid && !tready_q) begin
            held_data_d = s_axis.tdata;
         end
         if (handshake) begin
            rx_count_d  = rx_inc;
            data_lfsr_d = data_step;
            if (mismatch) begin
               if (err_count_q == '0) begin
                  first_data_d = s_axis.tdata;
                  first_exp_d  = exp_data;
               end
               if (err_count_q != '1) begin
                  err_count_d = err_count_q + 1'b1;
               end
            end
            if (rx_inc == target_q) begin
               state_d = ST_DONE;
            end
         end
      end

      tready_d = (state_d == ST_RUN) && ({1'b0, rdy_lfsr_d[3:0]} >= STALL_W);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q      <= ST_IDLE;
         data_lfsr_q  <= SEED;
         rdy_lfsr_q   <= READY_SEED;
         tready_q     <= 1'b0;
         target_q     <= '0;
         rx_count_q   <= '0;
         err_count_q  <= '0;
         first_data_q <= '0;
         first_exp_q  <= '0;
         held_data_q  <= '0;
         held_q       <= 1'b0;
         proto_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_lfsr_q  <= data_lfsr_d;
         rdy_lfsr_q   <= rdy_lfsr_d;
         tready_q     <= tready_d;
         target_q     <= target_d;
         rx_count_q   <= rx_count_d;
         err_count_q  <= err_count_d;
         first_data_q <= first_data_d;
         first_exp_q  <= first_exp_d;
         held_data_q  <= held_data_d;
         held_q       <= held_d;
         proto_q      <= proto_d;
      end
   end

   assign s_axis.tready    = tready_q;
   assign busy_o           = (state_q == ST_RUN);
   assign done_o           = (state_q == ST_DONE);
   assign pass_o           = done_o && (err_count_q == '0) && !proto_q;
   assign rx_count_o       = rx_count_q;
   assign error_count_o    = err_count_q;
   assign first_err_data_o = first_data_q;
   assign first_err_exp_o  = first_exp_q;
   assign protocol_err_o   = proto_q;
endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Scoreboard bench: three checker instances (stall weights 0, 8, 16) driven by directed
// beat sequences; run results are queued at start and compared when done rises.
module tb_axis_lfsr_checker;
   localparam int DW = 32;
   localparam int CW = 32;
   localparam int N  = 3;

   typedef struct {
      int          id;
      logic [CW-1:0] rx;
      logic [CW-1:0] err;
      logic [DW-1:0] fd;
      logic [DW-1:0] fe;
      logic        pass;
      logic        proto;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start    [N];
   logic [CW-1:0] target   [N];
   logic [DW-1:0] tdata    [N];
   logic          tvalid   [N];
   logic          tready   [N];
   logic          busy     [N];
   logic          done     [N];
   logic          pass_f   [N];
   logic          proto_f  [N];
   logic [CW-1:0] rx_cnt   [N];
   logic [CW-1:0] err_cnt  [N];
   logic [DW-1:0] fdat     [N];
   logic [DW-1:0] fexp     [N];

   int   checks = 0;
   int   errors = 0;
   int   pushes = 0;
   int   pops   = 0;
   int   rdy_cyc0   = 0;
   int   stall_cyc1 = 0;
   exp_t sb [$];
   exp_t mon_e;
   logic done_prev [N] = '{default: 1'b0};

   logic [31:0] clean_v [5] = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B};
   logic [31:0] bad_v   [5] = '{32'h1, 32'h3, 32'h7, 32'hD, 32'h1B};

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         axis_lfsr_checker_if #(.DATA_WIDTH(DW)) s_if ();
         assign s_if.tdata  = tdata[g];
         assign s_if.tvalid = tvalid[g];
         assign tready[g]   = s_if.tready;
         axis_lfsr_checker #(
            .DATA_WIDTH (DW),
            .SEED       (32'h0000_0001),
            .READY_SEED (16'hBEEF),
            .STALL_NUM  ((g == 0) ? 0 : ((g == 1) ? 8 : 16)),
            .COUNT_WIDTH(CW)
         ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start_i         (start[g]),
            .target_count_i  (target[g]),
            .s_axis          (s_if),
            .busy_o          (busy[g]),
            .done_o          (done[g]),
            .pass_o          (pass_f[g]),
            .rx_count_o      (rx_cnt[g]),
            .error_count_o   (err_cnt[g]),
            .first_err_data_o(fdat[g]),
            .first_err_exp_o (fexp[g]),
            .protocol_err_o  (proto_f[g])
         );
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no DUT response within the cycle budget, want a response", name);
   endtask

   function automatic logic [31:0] lfsr32(input logic [31:0] d);
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
   endfunction

   task automatic push_exp(input int id, input logic [CW-1:0] rx, input logic [CW-1:0] err,
                           input logic [DW-1:0] fd, input logic [DW-1:0] fe,
                           input logic pass, input logic proto);
      exp_t e;
      e.id = id; e.rx = rx; e.err = err; e.fd = fd; e.fe = fe; e.pass = pass; e.proto = proto;
      sb.push_back(e);
      pushes++;
   endtask

   // Monitor: each rising done is one finished run, compared against the oldest expectation.
   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (done[g] === 1'b1 && done_prev[g] !== 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_done: got done on dut%0d, want no run pending", g);
            end else begin
               mon_e = sb.pop_front();
               pops++;
               check($sformatf("run%0d_dut_id", pops), 64'(g), 64'(mon_e.id));
               check($sformatf("run%0d_rx_count", pops), 64'(rx_cnt[g]), 64'(mon_e.rx));
               check($sformatf("run%0d_error_count", pops), 64'(err_cnt[g]), 64'(mon_e.err));
               check($sformatf("run%0d_first_err_data", pops), 64'(fdat[g]), 64'(mon_e.fd));
               check($sformatf("run%0d_first_err_exp", pops), 64'(fexp[g]), 64'(mon_e.fe));
               check($sformatf("run%0d_pass", pops), 64'(pass_f[g]), 64'(mon_e.pass));
               check($sformatf("run%0d_protocol_err", pops), 64'(proto_f[g]), 64'(mon_e.proto));
            end
         end
         done_prev[g] = done[g];
      end
   end

   always @(negedge clk) begin
      if (tready[0] === 1'b1) rdy_cyc0++;
      if (tvalid[1] === 1'b1 && tready[1] === 1'b0) stall_cyc1++;
   end

   task automatic start_run(input int id, input logic [CW-1:0] n);
      @(posedge clk); #1;
      start[id]  = 1'b1;
      target[id] = n;
      @(posedge clk); #1;
      start[id]  = 1'b0;
   endtask

   // Presents one beat and holds it until accepted; returns at the accepting edge + 1.
   task automatic send_beat(input int id, input logic [31:0] d, output int waits, output bit ok);
      tdata[id]  = d;
      tvalid[id] = 1'b1;
      waits = 0;
      ok    = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (tready[id] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         waits++;
      end
      @(posedge clk); #1;
   endtask

   task automatic send_seq(input int id, input logic [31:0] v [5], input int n, output int waits);
      int  w;
      bit  ok;
      waits = 0;
      for (int i = 0; i < n; i++) begin
         send_beat(id, v[i], w, ok);
         waits += w;
         if (!ok) begin
            timeout($sformatf("beat%0d_accept_dut%0d", i, id));
            break;
         end
      end
   endtask

   task automatic wait_done(input int id);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (done[id] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeout($sformatf("done_dut%0d", id));
      @(posedge clk); #1;
   endtask

   initial begin
      int          waits;
      int          snap;
      bit          ok;
      logic [31:0] d;

      rst = 1'b1;
      for (int g = 0; g < N; g++) begin
         start[g] = 1'b0; target[g] = '0; tdata[g] = '0; tvalid[g] = 1'b0;
      end

      // Reset values, then valid held in IDLE must not be taken.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy[0]), 0);
      check("rst_done", 64'(done[0]), 0);
      check("rst_pass", 64'(pass_f[0]), 0);
      check("rst_rx_count", 64'(rx_cnt[0]), 0);
      check("rst_error_count", 64'(err_cnt[0]), 0);
      check("rst_first_err", 64'({fdat[0], fexp[0]}), 0);
      check("rst_protocol_err", 64'(proto_f[0]), 0);
      check("rst_tready", 64'({tready[0], tready[1], tready[2]}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tvalid[0] = 1'b1;
      tdata[0]  = 32'h5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_tready", 64'(tready[0]), 0);
      check("idle_rx_count", 64'(rx_cnt[0]), 0);
      check("idle_protocol_err", 64'(proto_f[0]), 0);

      // Clean back-to-back run.
      push_exp(0, 5, 0, 0, 0, 1'b1, 1'b0);
      @(posedge clk); #1;
      snap = rdy_cyc0;
      start_run(0, 5);
      send_seq(0, clean_v, 5, waits);
      tvalid[0] = 1'b0;
      check("clean_stall_cycles", 64'(waits), 0);
      wait_done(0);
      check("clean_tready_cycles", 64'(rdy_cyc0 - snap), 5);
      check("clean_tready_after_done", 64'(tready[0]), 0);
      check("clean_busy_after_done", 64'(busy[0]), 0);

      // Third beat corrupted; later beats still match.
      push_exp(0, 5, 1, 32'h7, 32'h6, 1'b0, 1'b0);
      start_run(0, 5);
      send_seq(0, bad_v, 5, waits);
      tvalid[0] = 1'b0;
      wait_done(0);

      // Backpressure with random valid bubbles.
      push_exp(1, 1000, 0, 0, 0, 1'b1, 1'b0);
      snap = stall_cyc1;
      start_run(1, 1000);
      d = 32'h1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tvalid[1] = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
         send_beat(1, d, waits, ok);
         if (!ok) begin
            timeout($sformatf("bp_beat%0d_accept", i));
            break;
         end
         d = lfsr32(d);
      end
      tvalid[1] = 1'b0;
      wait_done(1);
      check("bp_stall_seen", 64'(stall_cyc1 - snap > 0), 1);

      // Always-stall instance: tdata changes while stalled.
      start_run(2, 4);
      tvalid[2] = 1'b1;
      tdata[2]  = 32'h1;
      @(negedge clk);
      check("proto_busy", 64'(busy[2]), 1);
      check("proto_tready", 64'(tready[2]), 0);
      @(posedge clk); #1;
      tdata[2] = 32'h2;
      @(negedge clk);
      check("proto_before", 64'(proto_f[2]), 0);
      @(posedge clk);
      @(negedge clk);
      check("proto_set", 64'(proto_f[2]), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("proto_sticky", 64'(proto_f[2]), 1);
      @(posedge clk); #1;
      tvalid[2] = 1'b0;

      // Reset in the middle of a run.
      start_run(0, 10);
      send_seq(0, clean_v, 3, waits);
      check("abort_rx_before_rst", 64'(rx_cnt[0]), 3);
      check("abort_busy_before_rst", 64'(busy[0]), 1);
      tvalid[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_rx_count", 64'(rx_cnt[0]), 0);
      check("abort_busy", 64'(busy[0]), 0);
      check("abort_tready", 64'(tready[0]), 0);
      check("abort_proto_dut2", 64'(proto_f[2]), 0);
      check("abort_done_dut1", 64'(done[1]), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Zero-length run completes at once without a ready pulse.
      push_exp(0, 0, 0, 0, 0, 1'b1, 1'b0);
      snap = rdy_cyc0;
      start_run(0, 0);
      @(negedge clk);
      check("zero_done", 64'(done[0]), 1);
      check("zero_pass", 64'(pass_f[0]), 1);
      repeat (3) @(posedge clk);
      #1;
      check("zero_no_tready", 64'(rdy_cyc0 - snap), 0);

      // Restart after the abort resumes from SEED.
      push_exp(0, 3, 0, 0, 0, 1'b1, 1'b0);
      start_run(0, 3);
      send_seq(0, clean_v, 3, waits);
      tvalid[0] = 1'b0;
      wait_done(0);

      repeat (5) @(posedge clk);
      #1;
      check("sb_all_runs_seen", 64'(pops), 64'(pushes));
      check("sb_queue_empty", 64'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
